// File: rtl/ahblite_master_arbiter.sv
// ahblite_master_arbiter: shares one AHB-Lite bus between two masters via per-master holding registers, granting one transfer at a time
module ahblite_master_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [3:0]  m0_HPROT,
  input  logic [31:0] m0_HWDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,
  output logic [31:0] m0_HRDATA,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [3:0]  m1_HPROT,
  input  logic [31:0] m1_HWDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,
  output logic [31:0] m1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [1:0]  owner
);
  typedef enum logic [1:0] {IDLE, PEND, ADDR, DATA} state_t;
  state_t      state_q [2];
  state_t      state_d [2];
  logic [39:0] hold_q [2];
  logic [39:0] hold_d [2];
  logic [39:0] req [2];
  logic [1:0]  trans [2];
  logic [39:0] bus_q, bus_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        rr_q, rr_d;
  logic [1:0]  hrdy, cap, cand, gnt;
  assign req[0] = {m0_HADDR, m0_HWRITE, m0_HSIZE, m0_HPROT};
  assign req[1] = {m1_HADDR, m1_HWRITE, m1_HSIZE, m1_HPROT};
  assign trans[0] = m0_HTRANS;
  assign trans[1] = m1_HTRANS;
  for (genvar g = 0; g < 2; g++) begin : g_m
    assign hrdy[g]  = state_q[g] == IDLE || (state_q[g] == DATA && HREADY);
    assign cap[g]   = trans[g] inside {2'b10, 2'b11} && hrdy[g];
    assign cand[g]  = HREADY && (state_q[g] == PEND || cap[g]);
    assign owner[g] = state_q[g] == DATA;
  end
  assign gnt[0] = cand[0] && !(cand[1] && PRIORITY_MODE != 0 && rr_q);
  assign gnt[1] = cand[1] && !gnt[0];
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i] == ADDR ? (HREADY ? DATA : ADDR) :
                   (state_q[i] == DATA && !HREADY) ? DATA :
                   gnt[i] ? ADDR :
                   (state_q[i] == PEND || cap[i]) ? PEND : IDLE;
      hold_d[i]  = cap[i] ? req[i] : hold_q[i];
    end
    bus_d    = gnt[0] ? (cap[0] ? req[0] : hold_q[0]) :
               gnt[1] ? (cap[1] ? req[1] : hold_q[1]) : bus_q;
    htrans_d = !HREADY ? htrans_q : (|gnt ? 2'b10 : 2'b00);
    rr_d     = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : rr_q;
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        hold_q[i]  <= '0;
      end
      bus_q    <= '0;
      htrans_q <= '0;
      rr_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
      bus_q    <= bus_d;
      htrans_q <= htrans_d;
      rr_q     <= rr_d;
    end
  end
  assign HADDR     = bus_q[39:8];
  assign HWRITE    = bus_q[7];
  assign HSIZE     = bus_q[6:4];
  assign HPROT     = bus_q[3:0];
  assign HTRANS    = htrans_q;
  assign HBURST    = 3'b000;
  assign HWDATA    = owner[0] ? m0_HWDATA : owner[1] ? m1_HWDATA : '0;
  assign m0_HREADY = hrdy[0];
  assign m1_HREADY = hrdy[1];
  assign m0_HRESP  = owner[0] && HRESP;
  assign m1_HRESP  = owner[1] && HRESP;
  assign m0_HRDATA = HRDATA;
  assign m1_HRDATA = HRDATA;
endmodule
